instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Reverse direction of the core's opcode/control decode path: accepts a symbolic instruction (type code plus register fields, funct fields and a 32-bit immediate) and emits the packed RV32I instruction word.
- Emits with a sequential address, ready for writing into instruction memory.
- Used by the CNN host/loader path to build kernel programs on-chip.
- Expands the LI pseudo-instruction into LUI+ADDI over two output beats.

Parameters:
ADDR_W, 32, width of the output address counter
BASE_ADDR, 0, address of the first emitted word and the value restored by restart

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
restart  input  1  synchronous; in IDLE with out_valid=0, resets out_addr to BASE_ADDR and word_count to 0
in_valid  input  1  symbolic instruction present
in_ready  output  1  encoder can accept this cycle
in_type  input  3  0 LOAD, 1 STORE, 2 R, 3 BRANCH, 4 OPIMM, 5 JAL, 6 JALR, 7 LI
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3 field (ignored for JAL, LI)
in_funct7  input  7  funct7 field (R only)
in_imm  input  32  byte offset / immediate, two's complement
out_valid  output  1  out_instr/out_addr valid
out_ready  input  1  consumer accepts the word
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  byte address of out_instr
word_count  output  16  words emitted since reset/restart, wraps at 2^16
err  output  1  sticky; set on an illegal request (see Optional Feature); cleared by reset or restart

Behaviour:
- Reset (rst_n=0, async): state=IDLE, out_valid=0, out_instr=0, out_addr=BASE_ADDR, word_count=0, err=0, in_ready=0 while rst_n low.
- Handshakes: input transfer = in_valid&in_ready; output transfer = out_valid&out_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready); registered-output pipeline with no skid buffer.
- Latency: out_valid rises the cycle after an input transfer (1 cycle).
- While out_valid=1 and out_ready=0, out_instr and out_addr hold stable.
- On each output transfer: out_addr += 4 (wraps modulo 2^ADDR_W); word_count += 1.
- Encodings, opcode by type:
  - LOAD 0000011, I-format.
  - STORE 0100011, S-format: imm[11:5]->[31:25], imm[4:0]->[11:7].
  - R 0110011.
  - BRANCH 1100011, B-format: imm[12|10:5]->[31:25], imm[4:1|11]->[11:8|7].
  - OPIMM 0010011, I-format; funct7 is not inserted.
  - JAL 1101111, J-format: imm[20|10:1|11|19:12]->[31:12].
  - JALR 1100111, funct3=000.
- Immediate use: only the low 12/13/21 bits are used; upper bits are ignored unless range checking is enabled.
- LI handling:
  - If in_imm in [-2048, 2047]: single word ADDI rd,x0,imm.
  - Otherwise: hi = (in_imm + 0x800) >> 12 (32-bit add, wraps); lo = in_imm[11:0].
  - Emit LUI rd,hi (opcode 0110111), state goes to LI_LO holding ADDI rd,rd,lo.
  - On the LUI output transfer, out_instr <= ADDI word, out_valid stays 1, state goes to IDLE.
  - If lo==0, only the LUI is emitted.
- States: IDLE (accepting), LI_LO (second word pending). reset -> IDLE; IDLE -> LI_LO on an input transfer of a two-word LI; LI_LO -> IDLE on the LUI output transfer.
- restart outside IDLE, or while out_valid=1, is ignored.
- Reset asserted mid-LI discards the pending ADDI.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined:
  - Illegal requests: LOAD/STORE/OPIMM/JALR imm outside [-2048, 2047]; BRANCH imm odd or outside [-4096, 4094]; JAL imm odd or outside [-1048576, 1048574].
  - An illegal request is still accepted (in_ready unaffected), sets err, and produces no output word.
  - out_addr and word_count do not advance.
- Undefined: no checking; immediates are truncated as above; err is tied to 0.

Test Plan:
- R add: type=2, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> out_instr=0x002081B3 one cycle later, out_addr=0x0.
- LOAD: lw x5,8(x2) -> 0x00812283 at out_addr=0x4; BRANCH beq x1,x2,+8 -> 0x00208463 at out_addr=0x8.
- LI x1,5 -> single 0x00500093. LI x1,0x12345FFF -> 0x123460B7 then 0xFFF08093 on consecutive beats, in_ready=0 during LI_LO, word_count +2.
- Backpressure: out_ready=0 for 5 cycles after a valid word -> out_instr/out_addr stable, in_ready=0; release -> single transfer, no duplicate.
- With ENC_RANGE_CHECK_EN: BRANCH imm=3 -> err=1, no out_valid, out_addr unchanged. Then restart in IDLE -> err=0, out_addr=BASE_ADDR, word_count=0.
- Assert rst_n low in LI_LO with out_valid=1 -> all outputs at reset values immediately; after release, the next LI starts cleanly at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - symbolic-instruction input stream and encoded-word output stream
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_type;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with LI expansion; ENC_RANGE_CHECK_EN enables immediate range checking
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    instr_encoder_if.slave       bus,
    output logic [15:0]          word_count,
    output logic                 err
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic { IDLE, LI_LO } state_t;

    state_t      state;
    logic [31:0] lo_word;
    logic [31:0] enc_word;
    logic [31:0] enc_lo;
    logic        two_word;
    logic        illegal;
    logic        in_fire;
    logic        out_fire;
    logic        imm12_ok;
    logic [31:0] imm;
    logic [31:0] li_hi;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;

    assign imm      = bus.in_imm;
    assign rd       = bus.in_rd;
    assign rs1      = bus.in_rs1;
    assign rs2      = bus.in_rs2;
    assign f3       = bus.in_funct3;
    assign imm12_ok = (imm[31:11] == {21{imm[11]}});
    // Rounding by 0x800 compensates for ADDI sign-extending its low 12 bits.
    assign li_hi    = imm + 32'h0000_0800;

    assign bus.in_ready = rst_n && (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = bus.out_valid && bus.out_ready;

    always_comb begin
        enc_word = '0;
        enc_lo   = '0;
        two_word = 1'b0;
        case (bus.in_type)
            3'd0: enc_word = {imm[11:0], rs1, f3, rd, OP_LOAD};
            3'd1: enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            3'd2: enc_word = {bus.in_funct7, rs2, rs1, f3, rd, OP_R};
            3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            3'd4: enc_word = {imm[11:0], rs1, f3, rd, OP_OPIMM};
            3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            3'd6: enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            default: begin
                if (imm12_ok) begin
                    enc_word = {imm[11:0], 5'd0, 3'b000, rd, OP_OPIMM};
                end else begin
                    enc_word = {li_hi[31:12], rd, OP_LUI};
                    enc_lo   = {imm[11:0], rd, 3'b000, rd, OP_OPIMM};
                    two_word = (imm[11:0] != 12'd0);
                end
            end
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic err_q;

    always_comb begin
        illegal = 1'b0;
        case (bus.in_type)
            3'd0, 3'd1, 3'd4, 3'd6: illegal = !imm12_ok;
            3'd3: illegal = imm[0] || (imm[31:12] != {20{imm[12]}});
            3'd5: illegal = imm[0] || (imm[31:20] != {12{imm[20]}});
            default: illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (in_fire && illegal) begin
            err_q <= 1'b1;
        end else if (restart && state == IDLE && !bus.out_valid) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_addr  <= BASE_ADDR;
            word_count    <= '0;
            lo_word       <= '0;
        end else begin
            if (restart && state == IDLE && !bus.out_valid) begin
                bus.out_addr <= BASE_ADDR;
                word_count   <= '0;
            end
            if (out_fire) begin
                bus.out_addr <= bus.out_addr + ADDR_W'(4);
                word_count   <= word_count + 16'd1;
                // The ADDI half of an LI follows back-to-back without dropping valid.
                if (state == LI_LO) begin
                    bus.out_instr <= lo_word;
                    state         <= IDLE;
                end else begin
                    bus.out_valid <= 1'b0;
                end
            end
            if (in_fire && !illegal) begin
                bus.out_valid <= 1'b1;
                bus.out_instr <= enc_word;
                if (two_word) begin
                    lo_word <= enc_lo;
                    state   <= LI_LO;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard testbench for instr_encoder
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] word_count;
    logic        err;

    instr_encoder_if #(.ADDR_W(32)) bus ();

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .bus        (bus),
        .word_count (word_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_addr = 32'h0;
    int          exp_words = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] instr);
        sb.push_back('{instr: instr, addr: exp_addr});
        exp_addr += 32'd4;
        exp_words++;
    endtask

    task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_type   = t;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_word", bus.out_instr, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_instr", bus.out_instr, e.instr);
                chk("out_addr", bus.out_addr, e.addr);
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_type   = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;

        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_addr", bus.out_addr, 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #20 rst_n = 1'b1;

        expect_word(32'h002081B3);
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        chk("r_latency_valid", 32'(bus.out_valid), 32'd1);
        expect_word(32'h00812283);
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8);
        expect_word(32'h00208463);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        expect_word(32'h00512623);
        send(3'd1, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12);
        expect_word(32'h010000EF);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd7, 7'd0, 32'd16);
        expect_word(32'hFFF00193);
        send(3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFF_FFFF);
        expect_word(32'h00008067);
        send(3'd6, 5'd0, 5'd1, 5'd0, 3'd5, 7'd0, 32'd0);
        drain();
        chk("wc_basic", 32'(word_count), 32'(exp_words));

        expect_word(32'h00500093);
        send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_word(32'h123460B7);
        expect_word(32'hFFF08093);
        send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        @(negedge clk);
        chk("li_lo_in_ready", 32'(bus.in_ready), 32'd0);
        expect_word(32'h00001137);
        send(3'd7, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
        expect_word(32'h80000093);
        send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        drain();
        chk("wc_li", 32'(word_count), 32'(exp_words));

        bus.out_ready = 1'b0;
        expect_word(32'h010000EF);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_instr", bus.out_instr, 32'h010000EF);
            chk("bp_addr", bus.out_addr, exp_addr - 32'd4);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();
        chk("wc_bp", 32'(word_count), 32'(exp_words));

`ifdef ENC_RANGE_CHECK_EN
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        @(negedge clk);
        chk("range_err", 32'(err), 32'd1);
        chk("range_no_valid", 32'(bus.out_valid), 32'd0);
`else
        expect_word(32'h00208163);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        drain();
        chk("noerr", 32'(err), 32'd0);
`endif
        chk("addr_after_range", bus.out_addr, exp_addr);
        chk("wc_after_range", 32'(word_count), 32'(exp_words));

        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        exp_addr  = 32'h0;
        exp_words = 0;
        chk("restart_addr", bus.out_addr, exp_addr);
        chk("restart_wc", 32'(word_count), 32'd0);
        chk("restart_err", 32'(err), 32'd0);

        bus.out_ready = 1'b0;
        send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        @(negedge clk);
        chk("midli_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midli_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("midli_rst_instr", bus.out_instr, 32'd0);
        chk("midli_rst_addr", bus.out_addr, 32'd0);
        chk("midli_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        expect_word(32'h123460B7);
        expect_word(32'hFFF08093);
        send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        drain();
        chk("wc_after_reset", 32'(word_count), 32'(exp_words));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
